alu_mem_seq: RTL and testbench

Command sequencer that drives the memory-mapped ALU register bus as its sole master. Accepts one ALU operation (A, B, oper) per valid/ready handshake and writes the three operands to their registers. It then writes the exec trigger, waits a fixed number of cycles, reads the result back and returns it on a valid/ready response port. It sits between a software-facing command source and the ALU register slave, replacing ad-hoc bus driving in benches and top-levels.

---
 rtl/alu_mem_pkg.sv | 29 ++
 rtl/alu_mem_seq_if.sv | 29 ++
 rtl/alu_mem_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_mem_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mem_pkg.sv
// Shared types and register map for the ALU register-bus command sequencer.
package alu_mem_pkg;

  // Sequencer states, in bus-access order.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_A    = 4'd1,
    ST_WR_B    = 4'd2,
    ST_WR_OP   = 4'd3,
    ST_WR_EXEC = 4'd4,
    ST_WAIT    = 4'd5,
    ST_RD_REQ  = 4'd6,
    ST_RD_CAP  = 4'd7,
    ST_RSP     = 4'd8
  } state_t;

  // ALU slave register map.
  localparam int REG_A    = 0;
  localparam int REG_B    = 1;
  localparam int REG_OPER = 2;
  localparam int REG_CTRL = 3;

  // Bit position in REG_CTRL that triggers execution.
  localparam int EXEC_BIT = 0;

  // Opcode width.
  localparam int OPER_W = 3;

endpackage

// File: rtl/alu_mem_seq_if.sv
// Register bus between the sequencer (master) and the ALU register slave.
interface alu_mem_seq_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);

  logic                  enable;
  logic                  rd_wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output enable,
    output rd_wr,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  enable,
    input  rd_wr,
    input  addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/alu_mem_seq.sv
// Command sequencer: one ALU operation per command, executed over the
// register bus as write A, write B, write oper, write exec, wait, read result.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR_A    | bus write of operand A to REG_A
// ST_WR_B    | bus write of operand B to REG_B
// ST_WR_OP   | bus write of zero-extended opcode to REG_OPER
// ST_WR_EXEC | bus write of the exec bit to REG_CTRL
// ST_WAIT    | EXEC_WAIT idle cycles while the ALU computes
// ST_RD_REQ  | bus read strobe on REG_CTRL
// ST_RD_CAP  | slave returns data; captured into rsp_data
// ST_RSP     | rsp_valid high, holding until the consumer takes it
module alu_mem_seq
  import alu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int EXEC_WAIT  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [OPER_W-1:0]     cmd_oper,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  alu_mem_seq_if.master         bus
);

  // Wait counter counts down from EXEC_WAIT-1 to zero; sized for at least 1 bit.
  localparam int CNT_W     = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
  localparam int WAIT_LOAD = (EXEC_WAIT > 0) ? EXEC_WAIT - 1 : 0;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [OPER_W-1:0]     oper_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic                  enable_c;
  logic                  rd_wr_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic                  rsp_valid_c;
  logic                  cmd_hs;

  // Gated by reset so cmd_ready reads low for the whole reset assertion.
  assign cmd_ready = (state_q == ST_IDLE) && reset;
  assign cmd_hs    = cmd_valid && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_c;
  assign rsp_data  = rsp_data_q;

  assign bus.enable  = enable_c;
  assign bus.rd_wr   = rd_wr_c;
  assign bus.addr    = addr_c;
  assign bus.wr_data = wr_data_c;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command capture, wait down-counter and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      oper_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      if (cmd_hs) begin
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        oper_q <= cmd_oper;
      end
      if (state_q == ST_WR_EXEC) begin
        cnt_q <= CNT_W'(WAIT_LOAD);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == ST_RD_CAP) begin
        rsp_data_q <= bus.rd_data;
      end
    end
  end

  // Next-state and bus/response outputs; bus fields are zero when idle.
  always_comb begin
    state_d     = state_q;
    enable_c    = 1'b0;
    rd_wr_c     = 1'b0;
    addr_c      = '0;
    wr_data_c   = '0;
    rsp_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) state_d = ST_WR_A;
      end
      ST_WR_A: begin
        enable_c  = 1'b1;
        rd_wr_c   = 1'b1;
        addr_c    = ADDR_WIDTH'(REG_A);
        wr_data_c = a_q;
        state_d   = ST_WR_B;
      end
      ST_WR_B: begin
        enable_c  = 1'b1;
        rd_wr_c   = 1'b1;
        addr_c    = ADDR_WIDTH'(REG_B);
        wr_data_c = b_q;
        state_d   = ST_WR_OP;
      end
      ST_WR_OP: begin
        enable_c  = 1'b1;
        rd_wr_c   = 1'b1;
        addr_c    = ADDR_WIDTH'(REG_OPER);
        wr_data_c = DATA_WIDTH'(oper_q);
        state_d   = ST_WR_EXEC;
      end
      ST_WR_EXEC: begin
        enable_c            = 1'b1;
        rd_wr_c             = 1'b1;
        addr_c              = ADDR_WIDTH'(REG_CTRL);
        wr_data_c[EXEC_BIT] = 1'b1;
        state_d             = (EXEC_WAIT == 0) ? ST_RD_REQ : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        enable_c = 1'b1;
        addr_c   = ADDR_WIDTH'(REG_CTRL);
        state_d  = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid_c = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_mem_seq.sv
// Directed bench for alu_mem_seq: main instance with EXEC_WAIT=2 plus a
// second instance with EXEC_WAIT=0 sharing the command side.
module tb_alu_mem_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [2:0] cmd_oper = '0;
  logic       rsp_ready = 1'b0;

  logic       cmd_ready, rsp_valid, busy;
  logic [7:0] rsp_data;
  logic       cmd_ready0, rsp_valid0, busy0;
  logic [7:0] rsp_data0;

  int checks = 0;
  int failures = 0;

  alu_mem_seq_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_if ();
  alu_mem_seq_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_if0 ();

  alu_mem_seq #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .EXEC_WAIT(2)) u_dut (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .bus(bus_if)
  );

  alu_mem_seq #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .EXEC_WAIT(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .busy(busy0), .bus(bus_if0)
  );

  initial forever #5 clk = ~clk;

  // ALU slave model: 0 and, 1 add, 2 sub, others xor.
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a + b;
      3'd2:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  logic [7:0] s_a, s_b, s_res, s_a0, s_b0, s_res0;
  logic [2:0] s_op, s_op0;

  always @(posedge clk) begin
    if (bus_if.enable && bus_if.rd_wr) begin
      case (bus_if.addr)
        2'd0: s_a <= bus_if.wr_data;
        2'd1: s_b <= bus_if.wr_data;
        2'd2: s_op <= bus_if.wr_data[2:0];
        default: if (bus_if.wr_data[0]) s_res <= alu(s_a, s_b, s_op);
      endcase
    end else if (bus_if.enable && bus_if.addr == 2'd3) begin
      bus_if.rd_data <= s_res;
    end else begin
      bus_if.rd_data <= 8'h00;
    end
  end

  always @(posedge clk) begin
    if (bus_if0.enable && bus_if0.rd_wr) begin
      case (bus_if0.addr)
        2'd0: s_a0 <= bus_if0.wr_data;
        2'd1: s_b0 <= bus_if0.wr_data;
        2'd2: s_op0 <= bus_if0.wr_data[2:0];
        default: if (bus_if0.wr_data[0]) s_res0 <= alu(s_a0, s_b0, s_op0);
      endcase
    end else if (bus_if0.enable && bus_if0.addr == 2'd3) begin
      bus_if0.rd_data <= s_res0;
    end else begin
      bus_if0.rd_data <= 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bus_vec();
    return {bus_if.enable, bus_if.rd_wr, bus_if.addr, bus_if.wr_data};
  endfunction

  function automatic logic [11:0] bus_vec0();
    return {bus_if0.enable, bus_if0.rd_wr, bus_if0.addr, bus_if0.wr_data};
  endfunction

  logic [11:0] exp_bus [1:8];
  int acc [2];
  logic [7:0] rsp_seen [2];
  int n_acc, n_rsp, n_en, lat;

  initial begin
    // {enable, rd_wr, addr, wr_data} expected per cycle after acceptance
    exp_bus[1] = 12'hC12; exp_bus[2] = 12'hD34; exp_bus[3] = 12'hE01;
    exp_bus[4] = 12'hF01; exp_bus[5] = 12'h000; exp_bus[6] = 12'h000;
    exp_bus[7] = 12'hB00; exp_bus[8] = 12'h000;

    // Reset values
    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_bus", bus_vec(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // Command 1: 12 + 34 with the consumer stalled
    cmd_valid = 1'b1; cmd_a = 8'h12; cmd_b = 8'h34; cmd_oper = 3'd1;
    @(posedge clk);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmd_valid = 1'b0; cmd_a = 8'hFF; cmd_b = 8'hFF; cmd_oper = 3'd7;
      end
      if (i <= 8) begin
        chk($sformatf("c1_bus_%0d", i), bus_vec(), exp_bus[i]);
        chk($sformatf("c1_rsp_valid_%0d", i), rsp_valid, 0);
        chk($sformatf("c1_busy_%0d", i), busy, 1);
        chk($sformatf("c1_cmd_ready_%0d", i), cmd_ready, 0);
      end else begin
        chk("c1_rsp_valid", rsp_valid, 1);
        chk("c1_rsp_data", rsp_data, 8'h46);
      end
      if (i == 5) chk("w0_rd_req", bus_vec0(), 12'hB00);
      if (i == 6) begin
        chk("w0_after_rd", bus_vec0(), 12'h000);
        chk("w0_rsp_early", rsp_valid0, 0);
      end
      if (i == 7) begin
        chk("w0_rsp_valid", rsp_valid0, 1);
        chk("w0_rsp_data", rsp_data0, 8'h46);
      end
    end

    // Consumer stall holds the response
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold_valid_%0d", i), rsp_valid, 1);
      chk($sformatf("hold_data_%0d", i), rsp_data, 8'h46);
      chk($sformatf("hold_ready_%0d", i), cmd_ready, 0);
      chk($sformatf("hold_enable_%0d", i), bus_if.enable, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rel_rsp_valid", rsp_valid, 0);
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);

    // Back-to-back commands with cmd_valid held high
    n_acc = 0; n_rsp = 0; n_en = 0;
    cmd_valid = 1'b1; cmd_a = 8'h50; cmd_b = 8'h20; cmd_oper = 3'd2;
    for (int n = 0; n < 26; n++) begin
      if (cmd_valid && cmd_ready && n_acc < 2) begin
        acc[n_acc] = n;
        n_acc++;
      end else if (n_acc == 1) begin
        cmd_a = 8'h0F; cmd_b = 8'hF0; cmd_oper = 3'd3;
      end else if (n_acc == 2) begin
        cmd_valid = 1'b0;
      end
      if (rsp_valid && n_rsp < 2) begin
        rsp_seen[n_rsp] = rsp_data;
        n_rsp++;
      end
      if (bus_if.enable) n_en++;
      @(negedge clk);
    end
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_spacing", acc[1] - acc[0], 10);
    chk("b2b_responses", n_rsp, 2);
    chk("b2b_rsp0", rsp_seen[0], 8'h30);
    chk("b2b_rsp1", rsp_seen[1], 8'hFF);
    chk("b2b_bus_accesses", n_en, 10);
    chk("b2b_idle", busy, 0);

    // Reset during WAIT
    cmd_valid = 1'b1; cmd_a = 8'h07; cmd_b = 8'h03; cmd_oper = 3'd1;
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_enable", bus_if.enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);

    cmd_valid = 1'b1; cmd_a = 8'h10; cmd_b = 8'h05; cmd_oper = 3'd2;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rsp_valid && lat == 0) begin
        lat = i;
        chk("post_rst_rsp_data", rsp_data, 8'h0B);
      end
    end
    chk("post_rst_latency", lat, 9);
    chk("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
